// File: rtl/dsp_mult_acc_stream.sv
// Streaming multiply-accumulate with valid/ready flow control and whole-pipeline stall.
// Optional feature macro: DSP_MULT_SATURATE_EN (saturating truncation and accumulation).
module dsp_mult_acc_stream #(
    parameter int AX_WIDTH     = 27,
    parameter int AY_WIDTH     = 27,
    parameter int RESULT_WIDTH = 54,
    parameter int LATENCY      = 3,
    parameter int SIGNED       = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ivalid,
    output logic                    oready,
    input  logic [AX_WIDTH-1:0]     ax,
    input  logic [AY_WIDTH-1:0]     ay,
    input  logic                    acc,
    output logic                    ovalid,
    input  logic                    iready,
    output logic [RESULT_WIDTH-1:0] resulta
);

    localparam int RW = RESULT_WIDTH;
    localparam int PW = AX_WIDTH + AY_WIDTH;
    // Two guard bits keep both the exact product and an exact accumulate sum representable.
    localparam int WW = ((PW > RW) ? PW : RW) + 2;
    localparam bit IS_SIGNED = (SIGNED != 0);

`ifdef DSP_MULT_SATURATE_EN
    localparam logic [WW-1:0] ONE_W = WW'(1'b1);
    localparam logic [WW-1:0] MAX_W = IS_SIGNED ? ((ONE_W << (RW - 1)) - ONE_W)
                                                : ((ONE_W << RW) - ONE_W);
    localparam logic [WW-1:0] MIN_W = IS_SIGNED ? (~(ONE_W << (RW - 1)) + ONE_W)
                                                : {WW{1'b0}};

    function automatic logic [RW-1:0] sat_rw(input logic [WW-1:0] v);
        logic [RW-1:0] r;
        if ($signed(v) > $signed(MAX_W)) begin
            r = RW'(MAX_W);
        end else if ($signed(v) < $signed(MIN_W)) begin
            r = RW'(MIN_W);
        end else begin
            r = RW'(v);
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] widen(input logic [RW-1:0] v);
        logic [WW-1:0] w;
        if (IS_SIGNED) begin
            w = WW'($signed(v));
        end else begin
            w = WW'(v);
        end
        return w;
    endfunction
`endif

    logic          en_s;
    logic [WW-1:0] prod_s;
    logic          fin_vld_s;
    logic          fin_acc_s;
    logic [WW-1:0] fin_prod_s;
    logic          out_vld_q;
    logic [RW-1:0] res_q;
    logic [RW-1:0] res_d;

    assign en_s    = !reset && (iready || !out_vld_q);
    assign oready  = en_s;
    assign ovalid  = out_vld_q;
    assign resulta = res_q;

    // Exact product, extended according to operand signedness.
    always_comb begin
        if (IS_SIGNED) begin
            prod_s = WW'($signed(ax)) * WW'($signed(ay));
        end else begin
            prod_s = WW'(ax) * WW'(ay);
        end
    end

    if (LATENCY == 1) begin : g_direct
        assign fin_vld_s  = ivalid;
        assign fin_acc_s  = acc;
        assign fin_prod_s = prod_s;
    end else begin : g_pipe
        logic [LATENCY-2:0] vld_q;
        logic [LATENCY-2:0] acc_q;
        logic [WW-1:0]      prod_q [LATENCY-1];

        // Product delay line; every stage freezes together while en is low.
        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q <= '0;
                acc_q <= '0;
                for (int i = 0; i < LATENCY - 1; i++) begin
                    prod_q[i] <= {WW{1'b0}};
                end
            end else if (en_s) begin
                vld_q[0]  <= ivalid;
                acc_q[0]  <= acc;
                prod_q[0] <= prod_s;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    acc_q[i]  <= acc_q[i-1];
                    prod_q[i] <= prod_q[i-1];
                end
            end
        end

        assign fin_vld_s  = vld_q[LATENCY-2];
        assign fin_acc_s  = acc_q[LATENCY-2];
        assign fin_prod_s = prod_q[LATENCY-2];
    end

    // Next accumulator value; bubbles leave the previous result untouched.
    always_comb begin
        res_d = res_q;
        if (fin_vld_s) begin
`ifdef DSP_MULT_SATURATE_EN
            res_d = sat_rw((fin_acc_s ? widen(res_q) : {WW{1'b0}}) + widen(sat_rw(fin_prod_s)));
`else
            res_d = (fin_acc_s ? res_q : {RW{1'b0}}) + RW'(fin_prod_s);
`endif
        end else begin
            res_d = res_q;
        end
    end

    // Result/accumulator stage driving the output handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            res_q     <= {RW{1'b0}};
        end else if (en_s) begin
            out_vld_q <= fin_vld_s;
            res_q     <= res_d;
        end
    end

endmodule

// File: tb/tb_dsp_mult_acc_stream.sv
// Directed scoreboard bench for dsp_mult_acc_stream across three parameter sets.
module tb_dsp_mult_acc_stream;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic        a_ivalid, a_acc, a_iready, a_oready, a_ovalid;
    logic [26:0] a_ax, a_ay;
    logic [53:0] a_res;
    logic        b_ivalid, b_acc, b_iready, b_oready, b_ovalid;
    logic [7:0]  b_ax, b_ay;
    logic [15:0] b_res;
    logic        c_ivalid, c_acc, c_iready, c_oready, c_ovalid;
    logic [7:0]  c_ax, c_ay;
    logic [7:0]  c_res;

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] qc[$];

    dsp_mult_acc_stream u_a (
        .clock(clock), .reset(reset), .ivalid(a_ivalid), .oready(a_oready),
        .ax(a_ax), .ay(a_ay), .acc(a_acc), .ovalid(a_ovalid), .iready(a_iready),
        .resulta(a_res)
    );

    dsp_mult_acc_stream #(.AX_WIDTH(8), .AY_WIDTH(8), .RESULT_WIDTH(16), .LATENCY(4), .SIGNED(1)) u_b (
        .clock(clock), .reset(reset), .ivalid(b_ivalid), .oready(b_oready),
        .ax(b_ax), .ay(b_ay), .acc(b_acc), .ovalid(b_ovalid), .iready(b_iready),
        .resulta(b_res)
    );

    dsp_mult_acc_stream #(.AX_WIDTH(8), .AY_WIDTH(8), .RESULT_WIDTH(8), .LATENCY(1), .SIGNED(0)) u_c (
        .clock(clock), .reset(reset), .ivalid(c_ivalid), .oready(c_oready),
        .ax(c_ax), .ay(c_ay), .acc(c_acc), .ovalid(c_ovalid), .iready(c_iready),
        .resulta(c_res)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int u);
        case (u)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic send(input int u, input logic [31:0] x, input logic [31:0] y,
                        input logic ac, input logic [63:0] exp);
        logic rdy;
        bit   done;
        done = 1'b0;
        case (u)
            0:       begin a_ivalid = 1'b1; a_ax = x[26:0]; a_ay = y[26:0]; a_acc = ac; end
            1:       begin b_ivalid = 1'b1; b_ax = x[7:0];  b_ay = y[7:0];  b_acc = ac; end
            default: begin c_ivalid = 1'b1; c_ax = x[7:0];  c_ay = y[7:0];  c_acc = ac; end
        endcase
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clock);
            case (u)
                0:       rdy = a_oready;
                1:       rdy = b_oready;
                default: rdy = c_oready;
            endcase
            if (rdy) begin
                case (u)
                    0:       qa.push_back(exp);
                    1:       qb.push_back(exp);
                    default: qc.push_back(exp);
                endcase
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        chk("send_accepted", 64'(done), 64'd1);
    endtask

    task automatic idle(input int u);
        case (u)
            0:       a_ivalid = 1'b0;
            1:       b_ivalid = 1'b0;
            default: c_ivalid = 1'b0;
        endcase
    endtask

    task automatic drain(input int u);
        for (int k = 0; k < 60 && qsize(u) != 0; k++) begin
            @(posedge clock);
            #1;
        end
        chk("drain_empty", 64'(qsize(u)), 64'd0);
    endtask

    // Output monitors: every output transfer pops the oldest expected value.
    always @(negedge clock) begin
        if (a_ovalid && a_iready) begin
            if (qa.size() == 0) chk("a_unexpected_out", 64'(a_res), 64'hDEAD);
            else                chk("a_out", 64'(a_res), qa.pop_front());
        end
        if (b_ovalid && b_iready) begin
            if (qb.size() == 0) chk("b_unexpected_out", 64'(b_res), 64'hDEAD);
            else                chk("b_out", 64'(b_res), qb.pop_front());
        end
        if (c_ovalid && c_iready) begin
            if (qc.size() == 0) chk("c_unexpected_out", 64'(c_res), 64'hDEAD);
            else                chk("c_out", 64'(c_res), qc.pop_front());
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hold;
        int          w;
        logic [63:0] e1, e3;

        reset = 1'b1;
        a_ivalid = 1'b0; a_acc = 1'b0; a_iready = 1'b1; a_ax = '0; a_ay = '0;
        b_ivalid = 1'b0; b_acc = 1'b0; b_iready = 1'b1; b_ax = '0; b_ay = '0;
        c_ivalid = 1'b0; c_acc = 1'b0; c_iready = 1'b1; c_ax = '0; c_ay = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_a_oready", 64'(a_oready), 64'd0);
        chk("rst_a_ovalid", 64'(a_ovalid), 64'd0);
        chk("rst_a_res", 64'(a_res), 64'd0);
        chk("rst_b_ovalid", 64'(b_ovalid), 64'd0);
        chk("rst_c_res", 64'(c_res), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_a_oready", 64'(a_oready), 64'd1);
        chk("post_rst_b_oready", 64'(b_oready), 64'd1);
        chk("post_rst_c_oready", 64'(c_oready), 64'd1);
        @(posedge clock);
        #1;

        // Basic product, default parameters, latency 3
        send(0, 32'h07FF_FFFF, 32'd2, 1'b0, 64'h0FFF_FFFE);
        idle(0);
        chk("lat_a_c1", 64'(a_ovalid), 64'd0);
        @(posedge clock); #1;
        chk("lat_a_c2", 64'(a_ovalid), 64'd0);
        @(posedge clock); #1;
        chk("lat_a_c3", 64'(a_ovalid), 64'd1);
        chk("lat_a_res", 64'(a_res), 64'h0FFF_FFFE);
        drain(0);

        // Signed accumulate, back-to-back, consecutive outputs
        send(1, 32'h0000_00FD, 32'd5, 1'b0, 64'h0000_FFF1);
        send(1, 32'd4, 32'd4, 1'b1, 64'd1);
        send(1, 32'h0000_00FE, 32'h0000_00FE, 1'b1, 64'd5);
        idle(1);
        w = 0;
        while (!b_ovalid && w < 20) begin
            @(posedge clock); #1;
            w++;
        end
        chk("b_first_ovalid", 64'(b_ovalid), 64'd1);
        @(posedge clock); #1;
        chk("b_second_ovalid", 64'(b_ovalid), 64'd1);
        @(posedge clock); #1;
        chk("b_third_ovalid", 64'(b_ovalid), 64'd1);
        @(posedge clock); #1;
        chk("b_after_ovalid", 64'(b_ovalid), 64'd0);
        drain(1);

        // Backpressure on the latency-4 instance
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send(1, 32'(k + 1), 32'(k + 2), 1'b0, 64'((k + 1) * (k + 2)));
                end
                idle(1);
            end
            begin
                repeat (6) @(posedge clock);
                #1;
                b_iready = 1'b0;
                @(negedge clock);
                chk("stall_oready", 64'(b_oready), 64'd0);
                chk("stall_ovalid", 64'(b_ovalid), 64'd1);
                hold = b_res;
                repeat (2) begin
                    @(negedge clock);
                    chk("stall_oready_hold", 64'(b_oready), 64'd0);
                    chk("stall_res_stable", 64'(b_res), 64'(hold));
                end
                @(posedge clock);
                #1;
                b_iready = 1'b1;
            end
        join
        drain(1);

        // Accumulation across bubbles
        send(0, 32'd10, 32'd10, 1'b0, 64'd100);
        idle(0);
        repeat (5) begin
            @(posedge clock); #1;
        end
        send(0, 32'd1, 32'd1, 1'b1, 64'd101);
        idle(0);
        drain(0);

        // Wrap versus saturate on an 8-bit unsigned result, latency 1
`ifdef DSP_MULT_SATURATE_EN
        e1 = 64'h0000_00FF;
        e3 = 64'd255;
`else
        e1 = 64'h0000_0001;
        e3 = 64'd44;
`endif
        send(2, 32'd255, 32'd255, 1'b0, e1);
        send(2, 32'd200, 32'd1, 1'b0, 64'd200);
        send(2, 32'd100, 32'd1, 1'b1, e3);
        idle(2);
        drain(2);

        // Reset mid-flight drops in-flight work and clears the accumulator
        send(0, 32'd5, 32'd5, 1'b0, 64'd25);
        send(0, 32'd6, 32'd6, 1'b1, 64'd61);
        idle(0);
        reset = 1'b1;
        qa.delete();
        @(negedge clock);
        chk("midrst_oready", 64'(a_oready), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            chk("midrst_no_ovalid", 64'(a_ovalid), 64'd0);
        end
        chk("midrst_res_zero", 64'(a_res), 64'd0);
        @(posedge clock); #1;
        send(0, 32'd3, 32'd3, 1'b1, 64'd9);
        idle(0);
        drain(0);

        chk("final_qb_empty", 64'(qsize(1)), 64'd0);
        chk("final_qc_empty", 64'(qsize(2)), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
